// File: rtl/article_tile_writer.sv
// Writable WIDTH x HEIGHT tile buffer of 4-bit colour codes with an 8x8-cell display read port.
// Writes use valid/ready. A fill FSM clears the buffer after reset and on clear_req.
module article_tile_writer #(
  parameter int WIDTH  = 42,
  parameter int HEIGHT = 5,
  parameter int DEPTH  = WIDTH*HEIGHT,
  parameter int AW     = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       is_in_pixel,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic [3:0] pixel,
  input  logic       clear_req,
  input  logic [3:0] clear_val,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [3:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       wr_err
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int XW = AW + 3;
  localparam logic [XW-1:0] WIDTH_X  = XW'(WIDTH);
  localparam logic [XW-1:0] HEIGHT_X = XW'(HEIGHT);
  localparam logic [AW-1:0] LAST_A   = AW'(DEPTH-1);
  localparam logic [12:0]   WIDTH_R  = 13'(WIDTH);
  localparam logic [12:0]   DEPTH_R  = 13'(DEPTH);

  logic [3:0] mem [DEPTH];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [3:0]    fill_q, fill_d;
  logic [3:0]    pixel_q, pixel_d;
  logic          done_q, done_d;
  logic          wr_err_q, wr_err_d;

  // Write address is formed wide so an out-of-range column/row never aliases a valid cell.
  logic [XW-1:0] col_x, row_x, wr_addr_x;
  logic          wr_in_range, wr_fire, clr_last;
  logic [12:0]   rd_addr;
  logic          rd_hit;

  assign col_x       = {{(XW-6){1'b0}}, wr_col};
  assign row_x       = {{(XW-3){1'b0}}, wr_row};
  assign wr_addr_x   = col_x + row_x * WIDTH_X;
  assign wr_in_range = (col_x < WIDTH_X) && (row_x < HEIGHT_X);

  assign busy     = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_IDLE) && !clear_req;
  assign wr_fire  = wr_valid && wr_ready;
  assign clr_last = (state_q == ST_CLEAR) && (clr_addr_q == LAST_A);

  assign rd_addr = {6'b0, hc[9:3]} + {6'b0, vc[9:3]} * WIDTH_R;
  assign rd_hit  = is_in_pixel && (rd_addr < DEPTH_R);

  logic unused_bits;
  assign unused_bits = ^{hc[2:0], vc[2:0], wr_addr_x[XW-1:AW], rd_addr[12:AW]};

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_last) state_d = ST_IDLE;
      end
      default: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          fill_d     = clear_val;
        end
      end
    endcase
  end

  always_comb begin
    pixel_d  = rd_hit ? mem[rd_addr[AW-1:0]] : 4'h0;
    done_d   = clr_last;
    wr_err_d = wr_fire && !wr_in_range;
  end

  // Buffer contents are intentionally not reset; the post-reset clear initialises them.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR)
      mem[clr_addr_q] <= fill_q;
    else if (wr_fire && wr_in_range)
      mem[wr_addr_x[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      fill_q     <= '0;
      pixel_q    <= '0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
      pixel_q    <= pixel_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign pixel  = pixel_q;
  assign done   = done_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_article_tile_writer.sv
// Randomised scoreboard bench for article_tile_writer: an array model of the 42x5 buffer
// predicts every pixel read and wr_err pulse; a monitor process pops and compares.
module tb_article_tile_writer;
  localparam int W = 42;
  localparam int H = 5;
  localparam int D = W*H;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       is_in_pixel = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic [3:0] pixel;
  logic       clear_req = 1'b0;
  logic [3:0] clear_val = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] wr_col = '0;
  logic [2:0] wr_row = '0;
  logic [3:0] wr_data = '0;
  logic       busy, done, wr_err;

  article_tile_writer dut (
    .CLK(CLK), .RST_N(RST_N), .is_in_pixel(is_in_pixel), .hc(hc), .vc(vc),
    .pixel(pixel), .clear_req(clear_req), .clear_val(clear_val),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int ref_mem [D];
  int exp_q [$];
  logic rd_issue = 1'b0, rd_pend = 1'b0;
  logic err_issue = 1'b0, err_pend = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a read or write issued before an edge is judged after that edge.
  always @(posedge CLK) begin
    rd_pend  <= rd_issue;
    err_pend <= err_issue;
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if (rd_pend) begin
        if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
        else check("pixel", {28'b0, pixel}, exp_q.pop_front());
      end
      check("wr_err", {31'b0, wr_err}, {31'b0, err_pend});
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // One cycle of stimulus: optional display read and optional write, model updated
  // after the expected read is taken so same-cycle collisions see the old value.
  task automatic step(bit do_rd, int h, int v, bit inp, bit do_wr, int col, int row, int data);
    int a;
    if (do_rd) begin
      hc = 10'(h); vc = 10'(v); is_in_pixel = inp;
      a = (h / 8) + (v / 8) * W;
      exp_q.push_back((inp && a < D) ? ref_mem[a] : 0);
      rd_issue = 1'b1;
    end
    if (do_wr) begin
      wr_valid = 1'b1; wr_col = 6'(col); wr_row = 3'(row); wr_data = 4'(data);
      check("wr_ready_idle", {31'b0, wr_ready}, 1);
      if (col < W && row < H) ref_mem[col + row*W] = data & 15;
      else err_issue = 1'b1;
    end
    tick();
    rd_issue = 1'b0; err_issue = 1'b0; wr_valid = 1'b0; is_in_pixel = 1'b0;
  endtask

  task automatic wait_clear(string nm);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      check({nm, "_rdy_busy"}, {31'b0, wr_ready}, 0);
      check({nm, "_done_busy"}, {31'b0, done}, 0);
      n++;
      tick();
    end
    check({nm, "_len"}, n, D);
    check({nm, "_done"}, {31'b0, done}, 1);
    check({nm, "_busy_off"}, {31'b0, busy}, 0);
    check({nm, "_rdy_idle"}, {31'b0, wr_ready}, 1);
    tick();
    check({nm, "_done_once"}, {31'b0, done}, 0);
  endtask

  task automatic do_clear(int val, bit with_wr);
    clear_req = 1'b1; clear_val = 4'(val);
    if (with_wr) begin
      wr_valid = 1'b1; wr_col = 6'd1; wr_row = 3'd0; wr_data = 4'(~val);
    end
    #1;
    check("clr_rdy_low", {31'b0, wr_ready}, 0);
    tick();
    clear_req = 1'b0; wr_valid = 1'b0; clear_val = 4'($urandom);
    wait_clear("clr");
    for (int i = 0; i < D; i++) ref_mem[i] = val & 15;
  endtask

  task automatic scan_all();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        step(1, c*8 + int'($urandom_range(0, 7)), r*8 + int'($urandom_range(0, 7)), 1, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) ref_mem[i] = 0;
    repeat (3) tick();
    check("rst_pixel",  {28'b0, pixel}, 0);
    check("rst_ready",  {31'b0, wr_ready}, 0);
    check("rst_busy",   {31'b0, busy}, 1);
    check("rst_done",   {31'b0, done}, 0);
    check("rst_wr_err", {31'b0, wr_err}, 0);
    RST_N = 1'b1;
    wait_clear("boot");
    scan_all();

    // Single cell write, then every pixel of that cell with and without is_in_pixel.
    step(0, 0, 0, 0, 1, 3, 2, 4'hA);
    for (int y = 16; y < 24; y++)
      for (int x = 24; x < 32; x++) step(1, x, y, 1, 0, 0, 0, 0);
    for (int y = 16; y < 24; y++)
      for (int x = 24; x < 32; x++) step(1, x, y, 0, 0, 0, 0, 0);

    // Last cell accepted, then a column just past the edge is dropped.
    step(0, 0, 0, 0, 1, 41, 4, 4'h5);
    step(0, 0, 0, 0, 1, 42, 0, 4'h9);
    step(1, 41*8, 4*8, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 3, 5, 1, 0, 0, 0, 0);

    // Clear with a competing write; buffer ends up all 7.
    do_clear(7, 1);
    scan_all();

    // Reset in the middle of a clear.
    clear_req = 1'b1; clear_val = 4'h3;
    tick();
    clear_req = 1'b0;
    repeat (99) tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_pixel", {28'b0, pixel}, 0);
    check("mid_rst_ready", {31'b0, wr_ready}, 0);
    check("mid_rst_busy",  {31'b0, busy}, 1);
    check("mid_rst_done",  {31'b0, done}, 0);
    check("mid_rst_err",   {31'b0, wr_err}, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    wait_clear("rst2");
    for (int i = 0; i < D; i++) ref_mem[i] = 0;
    scan_all();

    // Read/write collision on cell 0, then a row beyond the buffer.
    step(1, 0, 0, 1, 1, 0, 0, 4'hC);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 40, 1, 0, 0, 0, 0);

    // Randomised traffic with occasional clears.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_clear(int'($urandom_range(0, 15)), 1'($urandom));
      end else begin
        step(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)) & ((k & 1) ? 63 : 1023),
             1'($urandom_range(0, 3) != 0), 1'($urandom),
             int'($urandom_range(0, 63)) & ((k & 2) ? 63 : 47), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)));
      end
    end
    scan_all();

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/article_tile_writer.md
Name: article_tile_writer

Overview:
- Writable counterpart of the fixed 42x5 text-article ROM.
- Holds a WIDTH x HEIGHT cell buffer of 4-bit colour codes that game logic fills at run time, for example score banners or dynamic messages.
- Writes arrive over a valid/ready port; an internal FSM bulk-clears the buffer.
- A display read port uses the same hc/vc 8x8-cell addressing as the article ROMs, so the block drops into the pixel mux in place of a ROM.

Parameters:
- WIDTH, 42, cells per row (8 px each)
- HEIGHT, 5, rows of cells (8 px each)
- DEPTH, WIDTH*HEIGHT, total cells
- AW, 8, cell address width; must satisfy 2^AW >= DEPTH

Ports:
- CLK  in  1  system/pixel clock
- RST_N  in  1  asynchronous active-low reset
- is_in_pixel  in  1  current beam position is inside the article window
- hc  in  10  horizontal counter relative to the window origin
- vc  in  10  vertical counter relative to the window origin
- pixel  out  4  registered colour code for the display mux
- clear_req  in  1  request a fill of the whole buffer
- clear_val  in  4  fill value, sampled when the clear is accepted
- wr_valid  in  1  cell write request
- wr_ready  out  1  block can accept a write this cycle
- wr_col  in  6  target column
- wr_row  in  3  target row
- wr_data  in  4  colour code to store
- busy  out  1  clear in progress
- done  out  1  one-cycle pulse when a clear finishes
- wr_err  out  1  one-cycle pulse when an out-of-range write is dropped

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=CLEAR, clr_addr=0, fill value=0.
  - pixel=0, wr_ready=0, busy=1, done=0, wr_err=0.
  - RAM contents are not reset.
  - When reset releases, the block clears the buffer to 0 automatically.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each cycle: write fill value to RAM[clr_addr], then clr_addr++.
  - When clr_addr reaches DEPTH-1, write that cell, then go to IDLE.
  - done=1 for exactly one cycle, the first cycle back in IDLE. busy=0 in that cycle.
  - A clear takes exactly DEPTH cycles (210 by default).
  - wr_ready=0 and busy=1 throughout CLEAR.
  - clear_req is ignored during CLEAR; it does not restart or queue.
- IDLE:
  - wr_ready = ~clear_req.
  - If clear_req=1: latch clear_val, set clr_addr=0, go to CLEAR next cycle.
  - A wr_valid in the same cycle is not accepted; clear has priority.
- Write accept:
  - A write is accepted when wr_valid & wr_ready on a rising edge.
  - If wr_col < WIDTH and wr_row < HEIGHT: RAM[wr_col + wr_row*WIDTH] <= wr_data on that edge.
  - Otherwise no RAM change, and wr_err=1 in the next cycle only.
  - Single-cycle acceptance allows back-to-back writes every cycle.
- Address arithmetic:
  - Products and sums are computed at least AW+3 bits wide, so there is no truncation before the range check.
- Display read:
  - rd_addr = hc[9:3] + vc[9:3]*WIDTH, computed 13 bits wide.
  - Next-cycle pixel = RAM[rd_addr] if is_in_pixel=1 and rd_addr < DEPTH; else 0.
  - Latency is exactly 1 clock from hc/vc/is_in_pixel to pixel. The display pipeline compensates.
  - The read port is independent of the FSM: reads continue during CLEAR and during writes.
- Collision: a read of a cell being written in the same cycle returns the old value (read-before-write). The new value is visible on the following read.
- Outputs:
  - done and wr_err are registered single-cycle pulses.
  - busy and wr_ready are decoded from registered state, plus clear_req for wr_ready.

Test Plan:
- Reset release, no stimulus -> busy=1 for 210 cycles, then done pulses once, wr_ready=1. Scan every cell with is_in_pixel=1 -> pixel=0.
- In IDLE, write col=3 row=2 data=0xA, then hc=24..31, vc=16..23 -> pixel=0xA one cycle after each sample. With is_in_pixel=0 at the same hc/vc -> pixel=0.
- Writes col=41 row=4 data=0x5 (accepted) and col=42 row=0 (dropped) -> cell 209 reads 0x5; wr_err pulses exactly once, in the cycle after the second write; cell 0 is unchanged.
- clear_req=1 with clear_val=0x7 and wr_valid=1 in the same cycle -> write not accepted (wr_ready=0). After 210 busy cycles all cells read 0x7 and done pulses.
- RST_N asserted at cycle 100 of a clear, then released -> all outputs return to reset values immediately. A fresh 210-cycle clear to 0 runs and all cells read 0.
- Write cell (0,0)=0xC while hc=0, vc=0 is being read -> the first pixel shows the old value, the next read shows 0xC. hc=0, vc=40 (rd_addr >= DEPTH) -> pixel=0.
